// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel interval timer: channel state
// encoding and the one-shot/periodic mode constants.
package timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage : timer_pkg

// File: rtl/timer_channel.sv
// One timer channel: counts shared ticks from 0 to a latched limit, in
// one-shot or periodic mode, with stop > start > tick priority.
module timer_channel
  import timer_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            start,
  input  logic            stop,
  input  logic            mode,
  input  logic [BITS-1:0] final_value,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            done
);

  ch_state_e       state;
  mode_e           run_mode;
  logic [BITS-1:0] limit;

  // NOTE: limit and run_mode are ordinary flops, not a memory, so they are
  // reset like the rest of the state and never hold X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CH_IDLE;
      run_mode <= ONE_SHOT;
      limit    <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the
      // pre-edge values of count/limit regardless of statement order.
      done <= 1'b0;
      unique case (state)
        CH_IDLE: begin
          if (start && !stop) begin
            limit    <= final_value;
            run_mode <= mode_e'(mode);
            count    <= '0;
            state    <= CH_RUN;
          end
        end
        CH_RUN: begin
          if (stop) begin
            count <= '0;
            state <= CH_IDLE;
          end else if (start) begin
            limit    <= final_value;
            run_mode <= mode_e'(mode);
            count    <= '0;
          end else if (tick) begin
            if (count == limit) begin
              done  <= 1'b1;
              count <= '0;
              if (run_mode == ONE_SHOT) state <= CH_IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

  assign busy = (state == CH_RUN);

endmodule : timer_channel

// File: rtl/timer_multi.sv
// Multi-channel programmable interval timer: shared tick source plus
// CHANNELS independent timer_channel instances. Optional prescaler under
// macro TIMER_MULTI_PRESCALE_EN.
module timer_multi #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 4,
  parameter int PRE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CHANNELS-1:0]      start,
  input  logic [CHANNELS-1:0]      stop,
  input  logic [CHANNELS-1:0]      mode,
  input  logic [CHANNELS*BITS-1:0] final_value,
`ifdef TIMER_MULTI_PRESCALE_EN
  input  logic [PRE_BITS-1:0]      prescale,
`endif
  output logic [CHANNELS*BITS-1:0] count,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0]      done
);

  logic tick;

`ifdef TIMER_MULTI_PRESCALE_EN
  logic [PRE_BITS-1:0] pre_cnt;

  // Free-running divider; only channel-independent en moves it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (pre_cnt == prescale) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = en && (pre_cnt == prescale);
`else
  localparam int unused_pre_bits = PRE_BITS;

  assign tick = en;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .BITS(BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst),
      .tick       (tick),
      .start      (start[i]),
      .stop       (stop[i]),
      .mode       (mode[i]),
      .final_value(final_value[i*BITS +: BITS]),
      .count      (count[i*BITS +: BITS]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule : timer_multi

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios with literal
// expectations plus randomized traffic against a tick-counting model.
module tb_timer_multi;

  localparam int BITS     = 8;
  localparam int CH       = 4;
  localparam int PRE_BITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en  = 1'b0;
  logic [CH-1:0]       start = '0;
  logic [CH-1:0]       stop  = '0;
  logic [CH-1:0]       mode  = '0;
  logic [CH*BITS-1:0]  final_value = '0;
  logic [PRE_BITS-1:0] prescale = 4'd2;
  logic [CH*BITS-1:0]  count;
  logic [CH-1:0]       busy;
  logic [CH-1:0]       done;

  int vectors = 0;
  int errors  = 0;

  timer_multi #(
    .BITS(BITS), .CHANNELS(CH), .PRE_BITS(PRE_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .final_value(final_value),
`ifdef TIMER_MULTI_PRESCALE_EN
    .prescale   (prescale),
`endif
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Model: a running channel remembers how many ticks it has seen since its
  // last start; the count is that number modulo the period limit+1.
  bit m_run  [CH];
  int m_ticks[CH];
  int m_lim  [CH];
  bit m_per  [CH];
  bit m_done [CH];
  int m_pre;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0; m_ticks[i] = 0; m_lim[i] = 0; m_per[i] = 0; m_done[i] = 0;
    end
    m_pre = 0;
  endtask

  task automatic model_step();
    bit t;
`ifdef TIMER_MULTI_PRESCALE_EN
    t = en && (m_pre == int'(prescale));
    if (en) m_pre = (m_pre == int'(prescale)) ? 0 : m_pre + 1;
`else
    t = en;
`endif
    for (int i = 0; i < CH; i++) begin
      m_done[i] = 0;
      if (m_run[i]) begin
        if (stop[i]) begin
          m_run[i] = 0;
        end else if (start[i]) begin
          m_lim[i] = int'(final_value[i*BITS +: BITS]);
          m_per[i] = mode[i];
          m_ticks[i] = 0;
        end else if (t) begin
          m_ticks[i]++;
          if (m_ticks[i] % (m_lim[i] + 1) == 0) begin
            m_done[i] = 1;
            if (!m_per[i]) m_run[i] = 0;
          end
        end
      end else if (start[i] && !stop[i]) begin
        m_run[i]   = 1;
        m_lim[i]   = int'(final_value[i*BITS +: BITS]);
        m_per[i]   = mode[i];
        m_ticks[i] = 0;
      end
    end
  endtask

  function automatic int exp_count(int i);
    return m_run[i] ? m_ticks[i] % (m_lim[i] + 1) : 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("count%0d", i), 32'(count[i*BITS +: BITS]), 32'(exp_count(i)));
      check($sformatf("busy%0d", i),  32'(busy[i]), 32'(m_run[i]));
      check($sformatf("done%0d", i),  32'(done[i]), 32'(m_done[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_fv(int i, int v);
    final_value[i*BITS +: BITS] = BITS'(v);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b1;

    // Periodic, limit 3 on channel 0
    en = 1'b1; set_fv(0, 3); mode[0] = 1'b1; start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    check("per_busy_e0", 32'(busy[0]), 32'd1);
    check("per_cnt_e0", 32'(count[0 +: BITS]), 32'd0);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k == 3) check("per_cnt_e3", 32'(count[0 +: BITS]), 32'd3);
      if (k == 4 || k == 8 || k == 12) check($sformatf("per_done_e%0d", k), 32'(done[0]), 32'd1);
      if (k == 5) check("per_done_e5", 32'(done[0]), 32'd0);
    end
    stop[0] = 1'b1; cycle(); stop[0] = 1'b0;

    // One-shot, limit 0 on channel 1
    set_fv(1, 0); mode[1] = 1'b0; start[1] = 1'b1;
    cycle();
    start[1] = 1'b0;
    cycle();
    check("os0_done", 32'(done[1]), 32'd1);
    check("os0_busy", 32'(busy[1]), 32'd0);
    check("os0_cnt", 32'(count[BITS +: BITS]), 32'd0);
    cycle();
    check("os0_done_end", 32'(done[1]), 32'd0);

    // Collisions on channel 2
    set_fv(2, 5); mode[2] = 1'b1; start[2] = 1'b1;
    cycle();
    start[2] = 1'b0;
    repeat (3) cycle();
    start[2] = 1'b1; stop[2] = 1'b1;
    cycle();
    start[2] = 1'b0; stop[2] = 1'b0;
    check("col_stop_busy", 32'(busy[2]), 32'd0);
    check("col_stop_done", 32'(done[2]), 32'd0);
    set_fv(2, 2); mode[2] = 1'b0; start[2] = 1'b1;
    cycle();
    start[2] = 1'b0;
    repeat (2) cycle();
    check("col_pre_cnt", 32'(count[2*BITS +: BITS]), 32'd2);
    start[2] = 1'b1;
    cycle();
    start[2] = 1'b0;
    check("col_rst_cnt", 32'(count[2*BITS +: BITS]), 32'd0);
    check("col_rst_done", 32'(done[2]), 32'd0);
    check("col_rst_busy", 32'(busy[2]), 32'd1);
    repeat (5) cycle();

    // Independence with en toggling
    set_fv(0, 2); mode[0] = 1'b1; set_fv(1, 4); mode[1] = 1'b0;
    start[1:0] = 2'b11;
    cycle();
    start = '0;
    for (int k = 0; k < 24; k++) begin
      en = 1'(($urandom_range(0, 3) != 0));
      cycle();
    end
    en = 1'b1; stop = '1; cycle(); stop = '0;

    // Reset asserted mid-run on channel 3
    set_fv(3, 5); mode[3] = 1'b1; start[3] = 1'b1;
    cycle();
    start[3] = 1'b0;
    repeat (2) cycle();
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    repeat (4) cycle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en = 1'($urandom_range(0, 4) != 0);
      for (int i = 0; i < CH; i++) begin
        start[i] = 1'($urandom_range(0, 19) == 0);
        stop[i]  = 1'($urandom_range(0, 39) == 0);
        mode[i]  = 1'($urandom_range(0, 1));
        set_fv(i, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 7)));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_timer_multi
